// File: rtl/cnt2421_seg_drv_pkg.sv
// cnt2421_pkg: 2421 code constants, seven-segment patterns and digit-select
// encoding shared by the 2421 segment driver and its encoder.
package cnt2421_pkg;

  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b0001;
  localparam logic [3:0] CODE_2 = 4'b0010;
  localparam logic [3:0] CODE_3 = 4'b0011;
  localparam logic [3:0] CODE_4 = 4'b0100;
  localparam logic [3:0] CODE_5 = 4'b1011;
  localparam logic [3:0] CODE_6 = 4'b1100;
  localparam logic [3:0] CODE_7 = 4'b1101;
  localparam logic [3:0] CODE_8 = 4'b1110;
  localparam logic [3:0] CODE_9 = 4'b1111;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_E = 7'b0000110;

  typedef enum logic {
    SEL_UNITS = 1'b0,
    SEL_TENS  = 1'b1
  } digit_sel_e;

  // Plain weighted sum 2-4-2-1; agrees with the legal table on legal codes.
  function automatic logic [3:0] weighted_2421(input logic [3:0] c);
    return {2'b00, c[3], 1'b0} + {1'b0, c[2], 2'b00} +
           {2'b00, c[1], 1'b0} + {3'b000, c[0]};
  endfunction

  // Returns {legal, value}; value is 0 for illegal codes.
  function automatic logic [4:0] decode_2421(input logic [3:0] c);
    case (c)
      CODE_0:  return {1'b1, 4'd0};
      CODE_1:  return {1'b1, 4'd1};
      CODE_2:  return {1'b1, 4'd2};
      CODE_3:  return {1'b1, 4'd3};
      CODE_4:  return {1'b1, 4'd4};
      CODE_5:  return {1'b1, 4'd5};
      CODE_6:  return {1'b1, 4'd6};
      CODE_7:  return {1'b1, 4'd7};
      CODE_8:  return {1'b1, 4'd8};
      CODE_9:  return {1'b1, 4'd9};
      default: return {1'b0, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/cnt2421_seg_drv_if.sv
// Signal bundle between the 2421 counter side and the segment driver.
// The master drives the 2421 digit; the slave (the driver) returns the
// decoded digits, flags and display lines.
interface cnt2421_seg_drv_if;
  logic [3:0] in_code;
  logic [3:0] units;
  logic [3:0] tens;
  logic       carry_out;
  logic       code_err;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output in_code,
    input  units, tens, carry_out, code_err, seg, an
  );

  modport slave (
    input  in_code,
    output units, tens, carry_out, code_err, seg, an
  );
endinterface

// File: rtl/cnt2421_seg_drv_seg7_enc.sv
// seg7_enc: digit (0..9) plus error flag to active-low {g..a} pattern.
// Error flag wins and shows E; out-of-range digits also show E.
module seg7_enc
  import cnt2421_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       err,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_E;
    if (!err) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/cnt2421_seg_drv.sv
// cnt2421_seg_drv: samples a 2421 digit, decodes it to units, counts
// 9->0 wraps into tens, and scans both digits onto an active-low 7-seg.
// Optional macro CNT2421_CODE_CHECK_EN: flag illegal codes (sticky code_err),
// hold the digits on them and show E on the units digit. Without it every
// code decodes by plain weighted sum and code_err is tied low.
module cnt2421_seg_drv
  import cnt2421_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  cnt2421_seg_drv_if.slave    bus
);

  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  logic [3:0]  in_reg;
  logic [3:0]  units;
  logic [3:0]  tens;
  logic        carry_out;
  logic        code_err;
  logic [3:0]  dec_val;
  logic        dec_ok;
  logic        wrap;
  logic [15:0] scan_cnt;
  digit_sel_e  sel;
  logic [3:0]  disp_digit;
  logic        disp_err;
  logic [6:0]  seg_nxt;
  logic [6:0]  seg_q;
  logic [1:0]  an_q;

`ifdef CNT2421_CODE_CHECK_EN
  logic [4:0] dec_word;
  assign dec_word = decode_2421(in_reg);
  assign dec_ok   = dec_word[4];
  assign dec_val  = dec_word[3:0];
`else
  assign dec_ok   = 1'b1;
  assign dec_val  = weighted_2421(in_reg);
`endif

  // Only a 9 -> 0 step counts as a wrap; any other arrival at 0 is ignored.
  assign wrap = dec_ok && (units == 4'd9) && (dec_val == 4'd0);

  // Stage 1: capture the upstream digit every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_reg <= 4'd0;
    else     in_reg <= bus.in_code;
  end

  // Stage 2: units follow the decoded digit, tens count wraps, carry pulses at 99->00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units     <= 4'd0;
      tens      <= 4'd0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (dec_ok) units <= dec_val;
      if (wrap) begin
        tens      <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        carry_out <= (tens == 4'd9);
      end
    end
  end

`ifdef CNT2421_CODE_CHECK_EN
  // Sticky illegal-code flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          code_err <= 1'b0;
    else if (!dec_ok) code_err <= 1'b1;
  end
`else
  assign code_err = 1'b0;
`endif

  // Scan timer: SCAN_DIV cycles per digit, toggle select at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= 16'd0;
      sel      <= SEL_UNITS;
    end else if (scan_cnt == SCAN_TC) begin
      scan_cnt <= 16'd0;
      sel      <= (sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Pick the digit to show; E override applies to the units digit only
  always_comb begin
    disp_digit = units;
    disp_err   = code_err;
    if (sel == SEL_TENS) begin
      disp_digit = tens;
      disp_err   = 1'b0;
    end
  end

  seg7_enc u_enc (
    .digit (disp_digit),
    .err   (disp_err),
    .seg   (seg_nxt)
  );

  // Register seg and an together so both change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_0;
      an_q  <= 2'b10;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= (sel == SEL_UNITS) ? 2'b10 : 2'b01;
    end
  end

  assign bus.units     = units;
  assign bus.tens      = tens;
  assign bus.carry_out = carry_out;
  assign bus.code_err  = code_err;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_cnt2421_seg_drv.sv
// Bench for cnt2421_seg_drv with SCAN_DIV=4: directed counting, 99->00 wrap,
// non-wrap zero, illegal code, scan check, then random 2421 stimulus against
// a value-level model (units, wrap count, display slot from edge count).
module tb_cnt2421_seg_drv;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cnt2421_seg_drv_if bus ();

  cnt2421_seg_drv #(.SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int         lut [16];
  logic [6:0] pat [11];
  logic [3:0] enc [10];

  int         m_units, m_tens, m_wraps, m_carry, m_err, m_k;
  logic [3:0] m_in;
  logic [6:0] e_seg;
  logic [1:0] e_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dec_model(input logic [3:0] c);
    if (lut[c] >= 0) return lut[c];
`ifdef CNT2421_CODE_CHECK_EN
    return -1;
`else
    return 2 * int'(c[3]) + 4 * int'(c[2]) + 2 * int'(c[1]) + int'(c[0]);
`endif
  endfunction

  task automatic model_reset();
    m_units = 0; m_tens = 0; m_wraps = 0; m_carry = 0; m_err = 0;
    m_k = 0; m_in = 4'd0;
  endtask

  // One clock edge of the reference: display from pre-edge values, then digits.
  task automatic model_edge(input logic [3:0] c);
    int v;
    m_k++;
    if ((((m_k - 1) / SD) % 2) == 0) begin
      e_an  = 2'b10;
      e_seg = (m_err != 0) ? pat[10] : pat[m_units];
    end else begin
      e_an  = 2'b01;
      e_seg = pat[m_tens];
    end
    v = dec_model(m_in);
    m_carry = 0;
    if (v < 0) m_err = 1;
    else begin
      if (m_units == 9 && v == 0) begin
        m_wraps++;
        m_tens  = m_wraps % 10;
        m_carry = (m_tens == 0) ? 1 : 0;
      end
      m_units = v;
    end
    m_in = c;
  endtask

  task automatic check_all();
    chk("units", 32'(bus.units), 32'(m_units));
    chk("tens", 32'(bus.tens), 32'(m_tens));
    chk("carry_out", 32'(bus.carry_out), 32'(m_carry));
    chk("code_err", 32'(bus.code_err), 32'(m_err));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("an", 32'(bus.an), 32'(e_an));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [3:0] c);
    bus.in_code = c;
    @(posedge clk);
    model_edge(c);
    #1 check_all();
    @(negedge clk);
  endtask

  // Async reset asserted mid-cycle; outputs checked before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_units", 32'(bus.units), 32'd0);
    chk("rst_tens", 32'(bus.tens), 32'd0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
    chk("rst_err", 32'(bus.code_err), 32'd0);
    chk("rst_seg", 32'(bus.seg), 32'(7'b1000000));
    chk("rst_an", 32'(bus.an), 32'(2'b10));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt;
    int r;
    logic [3:0] code;

    enc[0] = 4'b0000; enc[1] = 4'b0001; enc[2] = 4'b0010; enc[3] = 4'b0011;
    enc[4] = 4'b0100; enc[5] = 4'b1011; enc[6] = 4'b1100; enc[7] = 4'b1101;
    enc[8] = 4'b1110; enc[9] = 4'b1111;
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
    pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
    pat[9] = 7'b0010000; pat[10] = 7'b0000110;
    for (int i = 0; i < 16; i++) lut[i] = -1;
    for (int i = 0; i < 10; i++) lut[enc[i]] = i;

    bus.in_code = 4'd0;
    model_reset();
    do_reset();

    // Count 0..9,0: tens 0->1, no carry
    for (int i = 0; i <= 10; i++) cycle(enc[i % 10]);
    cycle(enc[0]);

    // 100 further decades: passes 99->00 with a one-cycle carry
    for (int i = 1; i <= 1000; i++) cycle(enc[i % 10]);
    cycle(enc[0]);

    // Non-wrap zero
    cycle(enc[5]); cycle(enc[5]); cycle(enc[0]); cycle(enc[0]); cycle(enc[0]);

    // Illegal code after units=3 (held or weighted depending on build)
    cycle(enc[3]); cycle(enc[3]); cycle(4'b0110); cycle(enc[3]);
    for (int i = 0; i < 10; i++) cycle(enc[i]);

    // Scan: units=7, tens=2
    do_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 1; i <= 10; i++) cycle(enc[i % 10]);
    for (int i = 0; i < 20; i++) cycle(enc[7]);

    // Random mostly-counting stimulus with an async reset halfway
    cnt = 0;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        do_reset();
        cnt = 0;
      end
      r = int'($urandom_range(0, 99));
      if (r < 85) begin
        cnt = (cnt + 1) % 10;
        code = enc[cnt];
      end else if (r < 93) begin
        code = 4'($urandom_range(0, 15));
      end else begin
        code = enc[0];
      end
      cycle(code);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
